// File: rtl/ysyx_25030093_lsu_ctrl_if.sv
// Load/store controller bus bundle: execute-side request, memory bus and
// execute-side response. The master modport is the controller's view; the
// slave modport is the view of the surrounding execute stage and memory.
interface ysyx_25030093_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_base;
  logic [31:0] req_off;
  logic [31:0] req_wdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;

  modport master (
    input  req_valid, req_op, req_base, req_off, req_wdata,
    output req_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output rsp_valid, rsp_data, rsp_fault,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_base, req_off, req_wdata,
    input  req_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  rsp_valid, rsp_data, rsp_fault,
    output rsp_ready
  );
endinterface

// File: rtl/ysyx_25030093_lsu_ctrl.sv
// Multi-cycle load/store controller: accepts one op from execute, runs a
// single valid/ready bus access with a bounded wait, and returns the
// extended load result or a fault code through a response handshake.
module ysyx_25030093_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_25030093_lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_SW  = 5'd17,
    OP_LW  = 5'd18,
    OP_LBU = 5'd21,
    OP_SH  = 5'd22,
    OP_SB  = 5'd23,
    OP_LHU = 5'd24,
    OP_LB  = 5'd25,
    OP_LH  = 5'd26
  } op_e;

  typedef enum logic [1:0] {F_OK, F_ALIGN, F_BUS, F_TIMEOUT} fault_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state, state_nxt;
  logic [15:0] cnt;
  logic [4:0]  op_q;
  logic [1:0]  lane_q;

  logic [31:0] ea;
  logic        legal;
  logic        is_load;
  logic        misal;
  logic        acc_fault;
  logic [3:0]  acc_strb;
  logic [31:0] acc_wdata;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Decode the presented request: effective address, legality, alignment and lane placement.
  always_comb begin
    ea        = bus.req_base + bus.req_off;
    legal     = 1'b1;
    is_load   = 1'b0;
    misal     = 1'b0;
    acc_strb  = '0;
    acc_wdata = '0;
    case (bus.req_op)
      OP_SW: begin
        misal     = (ea[1:0] != 2'b00);
        acc_strb  = 4'b1111;
        acc_wdata = bus.req_wdata;
      end
      OP_SH: begin
        misal     = ea[0];
        acc_strb  = 4'b0011 << ea[1:0];
        acc_wdata = {2{bus.req_wdata[15:0]}};
      end
      OP_SB: begin
        acc_strb  = 4'b0001 << ea[1:0];
        acc_wdata = {4{bus.req_wdata[7:0]}};
      end
      OP_LW: begin
        is_load = 1'b1;
        misal   = (ea[1:0] != 2'b00);
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        misal   = ea[0];
      end
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    acc_fault = !legal || misal;
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    shifted  = bus.mem_rdata >> {lane_q, 3'b000};
    load_val = '0;
    case (op_q)
      OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_val = {24'b0, shifted[7:0]};
      OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_val = {16'b0, shifted[15:0]};
      OP_LW:   load_val = shifted;
      default: load_val = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt         = state;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.rsp_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = acc_fault ? S_DONE : S_REQ;
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_resp_valid || cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch at accept, wait counter, and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wen   <= 1'b0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_fault <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            lane_q        <= ea[1:0];
            bus.mem_addr  <= {ea[31:2], 2'b00};
            bus.mem_wen   <= !is_load && !acc_fault;
            bus.mem_wstrb <= acc_fault ? 4'b0000 : acc_strb;
            bus.mem_wdata <= acc_fault ? 32'b0 : acc_wdata;
            bus.rsp_data  <= '0;
            bus.rsp_fault <= acc_fault ? F_ALIGN : F_OK;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) cnt <= '0;
        end
        S_WAIT: begin
          cnt <= cnt + 16'd1;
          // A response in the final counted cycle still wins over the timeout.
          if (bus.mem_resp_valid) begin
            bus.rsp_data  <= bus.mem_resp_err ? 32'b0 : load_val;
            bus.rsp_fault <= bus.mem_resp_err ? F_BUS : F_OK;
          end else if (cnt == CNT_LAST) begin
            bus.rsp_data  <= '0;
            bus.rsp_fault <= F_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu_ctrl.sv
// Self-checking bench for the load/store controller: directed scenarios from
// the feature list plus randomized ops against a byte-level reference model.
module tb_ysyx_25030093_lsu_ctrl;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  ysyx_25030093_lsu_ctrl_if bus ();

  ysyx_25030093_lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random request-side activity while the controller is busy; must be ignored.
  task automatic noise(input bit en);
    if (en) begin
      bus.req_valid = 1'($urandom);
      bus.req_op    = 5'($urandom);
      bus.req_base  = $urandom;
      bus.req_off   = $urandom;
      bus.req_wdata = $urandom;
    end
  endtask

  // Reference: byte-level view of which lanes a legal access touches.
  function automatic void model_req(input logic [4:0] op, input logic [31:0] base, off, wd,
                                    output bit f1, output bit ld, output int size, output bit sgn,
                                    output logic [31:0] addr, output bit wen,
                                    output logic [3:0] strb, output logic [31:0] wdat, output int lane);
    logic [31:0] ea;
    bit legal;
    ea = base + off;
    lane = int'(ea % 4);
    addr = ea - 32'(lane);
    legal = 1; ld = 0; sgn = 0; size = 4;
    case (op)
      5'd17: size = 4;
      5'd22: size = 2;
      5'd23: size = 1;
      5'd18: begin ld = 1; size = 4; end
      5'd24: begin ld = 1; size = 2; end
      5'd21: begin ld = 1; size = 1; end
      5'd25: begin ld = 1; size = 1; sgn = 1; end
      5'd26: begin ld = 1; size = 2; sgn = 1; end
      default: legal = 0;
    endcase
    f1 = !legal || (lane % size != 0);
    wen = 0; strb = '0; wdat = '0;
    if (!ld) begin
      wen = 1;
      for (int i = 0; i < 4; i++) begin
        if (i >= lane && i < lane + size) strb[i] = 1'b1;
        wdat[8*i +: 8] = wd[8*(i % size) +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int lane, size, input bit sgn);
    longint unsigned v, span;
    span = 64'd1 << (8*size);
    v = ({32'b0, rd} >> (8*lane)) % span;
    if (sgn && v >= span/2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  // One full transaction from IDLE back to IDLE with cycle-exact checks.
  task automatic do_txn(input logic [4:0] op, input logic [31:0] base, off, wd, rd,
                        input int req_lat, resp_lat, rsp_lat, input bit err, stray, noisy);
    bit f1, ld, sgn, wen, tmo;
    int size, lane;
    logic [31:0] addr, wdat, ed;
    logic [3:0] strb;
    logic [1:0] ef;
    model_req(op, base, off, wd, f1, ld, size, sgn, addr, wen, strb, wdat, lane);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%b exp=1", bus.req_ready);
    end
    bus.req_valid = 1; bus.req_op = op; bus.req_base = base; bus.req_off = off; bus.req_wdata = wd;
    tick();
    bus.req_valid = 0;
    ef = 2'd1; ed = '0;
    if (!f1) begin
      for (int i = 0; i <= req_lat; i++) begin
        checks++;
        if ({bus.mem_req_valid, bus.rsp_valid, bus.mem_addr, bus.mem_wen, bus.mem_wstrb} !== {2'b10, addr, wen, strb}) begin
          failures++;
          $display("FAIL req_fields op=%0d got v=%b a=%h w=%b s=%b exp a=%h w=%b s=%b", op,
                   bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wstrb, addr, wen, strb);
        end
        if (!ld) begin
          checks++;
          if (bus.mem_wdata !== wdat) begin
            failures++; $display("FAIL req_wdata op=%0d got=%h exp=%h", op, bus.mem_wdata, wdat);
          end
        end
        bus.mem_req_ready = (i == req_lat);
        noise(noisy);
        tick();
      end
      bus.mem_req_ready = 0;
      tmo = 1;
      for (int k = 0; k < T; k++) begin
        checks++;
        if ({bus.mem_req_valid, bus.rsp_valid, bus.req_ready} !== 3'b000) begin
          failures++;
          $display("FAIL wait_state k=%0d got=%b exp=000", k, {bus.mem_req_valid, bus.rsp_valid, bus.req_ready});
        end
        if (k == resp_lat) begin
          bus.mem_resp_valid = 1; bus.mem_rdata = rd; bus.mem_resp_err = err;
          noise(noisy);
          tick();
          bus.mem_resp_valid = 0; bus.mem_resp_err = 0; tmo = 0;
          break;
        end
        bus.mem_resp_err = 1'($urandom); bus.mem_rdata = $urandom;
        noise(noisy);
        tick();
      end
      bus.mem_resp_err = 0;
      ef = tmo ? 2'd3 : (err ? 2'd2 : 2'd0);
      ed = (tmo || err || !ld) ? 32'h0 : model_load(rd, lane, size, sgn);
    end
    for (int j = 0; j <= rsp_lat; j++) begin
      checks++;
      if ({bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.rsp_fault, bus.rsp_data} !== {3'b001, ef, ed}) begin
        failures++;
        $display("FAIL done_rsp op=%0d got rdy=%b mv=%b v=%b f=%0d d=%h exp v=1 f=%0d d=%h", op,
                 bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.rsp_fault, bus.rsp_data, ef, ed);
      end
      bus.rsp_ready = (j == rsp_lat);
      if (stray) begin
        bus.mem_resp_valid = 1; bus.mem_rdata = $urandom; bus.mem_resp_err = 1'($urandom);
      end
      noise(noisy);
      tick();
    end
    bus.rsp_ready = 0; bus.req_valid = 0; bus.mem_resp_valid = 0; bus.mem_resp_err = 0;
    checks++;
    if ({bus.req_ready, bus.mem_req_valid, bus.rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL back_idle got=%b exp=100", {bus.req_ready, bus.mem_req_valid, bus.rsp_valid});
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({bus.req_ready, bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
         bus.rsp_valid, bus.rsp_data, bus.rsp_fault} !== {3'b100, 4'b0, 32'b0, 32'b0, 1'b0, 32'b0, 2'b0}) begin
      failures++;
      $display("FAIL %s got rdy=%b mv=%b wen=%b s=%b a=%h wd=%h v=%b d=%h f=%0d exp rdy=1 rest=0", tag,
               bus.req_ready, bus.mem_req_valid, bus.mem_wen, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
               bus.rsp_valid, bus.rsp_data, bus.rsp_fault);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    check_reset_vals("reset_values");
    rst = 0;
    tick();
  endtask

  task automatic test_sw();
    do_txn(5'd17, 32'h8000_0000, 32'd4, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_loads();
    do_txn(5'd25, 32'h8000_0000, 32'd3, 32'h0, 32'h8011_2233, 0, 0, 0, 0, 0, 0);
    do_txn(5'd21, 32'h8000_0000, 32'd3, 32'h0, 32'h8011_2233, 0, 0, 0, 0, 0, 0);
    do_txn(5'd26, 32'h8000_0000, 32'd2, 32'h0, 32'h8011_2233, 1, 2, 0, 0, 0, 0);
    do_txn(5'd24, 32'h8000_0000, 32'd2, 32'h0, 32'h8011_2233, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_sh_misaligned();
    do_txn(5'd22, 32'h8000_0000, 32'd2, 32'h0000_ABCD, 32'h0, 0, 0, 0, 0, 0, 0);
    do_txn(5'd26, 32'h8000_0000, 32'd1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    do_txn(5'd18, 32'h8000_0000, 32'd2, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    do_txn(5'd3,  32'h8000_0000, 32'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_err();
    do_txn(5'd23, 32'h8000_0100, 32'd1, 32'h0000_005A, 32'hFFFF_FFFF, 5, 0, 0, 1, 0, 0);
  endtask

  task automatic test_timeout();
    do_txn(5'd18, 32'h8000_0040, 32'd0, 32'h0, 32'h1111_2222, 0, 100, 3, 0, 1, 0);
    // Stray response while idle must not start anything.
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_resp_valid = 0;
    checks++;
    if ({bus.req_ready, bus.mem_req_valid, bus.rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL idle_stray got=%b exp=100", {bus.req_ready, bus.mem_req_valid, bus.rsp_valid});
    end
    do_txn(5'd18, 32'h8000_0040, 32'd0, 32'h0, 32'h3333_4444, 0, T-1, 0, 0, 0, 0);
    do_txn(5'd18, 32'h8000_0040, 32'd0, 32'h0, 32'h3333_4444, 0, T, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1; bus.req_op = 5'd18; bus.req_base = 32'h8000_0020; bus.req_off = 32'd0;
    tick();
    bus.req_valid = 0; bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    tick();
    #2 rst = 1;
    #1 check_reset_vals("async_reset");
    bus.mem_resp_valid = 1; bus.mem_rdata = 32'hFFFF_0000;
    tick();
    bus.mem_resp_valid = 0;
    rst = 0;
    tick();
    check_reset_vals("post_reset_idle");
    do_txn(5'd18, 32'h8000_0000, 32'h10, 32'h0, 32'h1234_5678, 0, 0, 3, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn(5'd17, 32'h8000_0200, 32'(4*i), $urandom, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [4:0] ops [8] = '{5'd17, 5'd22, 5'd23, 5'd18, 5'd24, 5'd21, 5'd25, 5'd26};
    logic [4:0] op;
    for (int n = 0; n < 80; n++) begin
      op = ($urandom % 10 == 0) ? 5'($urandom) : ops[$urandom % 8];
      do_txn(op, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, T + 1), $urandom_range(0, 2),
             ($urandom % 4 == 0), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = '0; bus.req_base = '0; bus.req_off = '0; bus.req_wdata = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0; bus.mem_resp_err = 0;
    bus.rsp_ready = 0;
    test_reset();
    test_sw();
    test_loads();
    test_sh_misaligned();
    test_stall_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
